// File: rtl/dmem_responder.sv
// Byte-addressed, big-endian data memory with a valid/ready request handshake
// and a fixed access latency; one request in flight at a time.
module dmem_responder #(
  parameter int SIZE    = 16384,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        memRst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [31:0] addr,
  input  logic [31:0] wData,
  input  logic        writeEnable,
  input  logic [1:0]  dsize,
  output logic        respValid,
  output logic [31:0] rData,
  output logic        misalign
);

  localparam int AW    = $clog2(SIZE);
  localparam int DEPTH = SIZE / 4;
  localparam int CW    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          mis_q;

  logic          accept;
  logic          do_access;
  logic [AW-1:0] op_addr;
  logic [31:0]   op_wdata;
  logic          op_we;
  logic [1:0]    op_size;
  logic          op_mis;
  logic [2:0]    op_bytes;
  logic [2:0]    op_off3;
  logic [2:0]    op_shift;
  logic [31:0]   wr_word;
  logic [31:0]   rd_word;
  logic [3:0]    lane_we;
  logic          unused_addr_hi;

  // High address bits are ignored: the array wraps modulo SIZE.
  assign unused_addr_hi = ^addr[31:AW];

  assign accept = reqValid & reqReady & ~memRst;

  always_ff @(posedge clk or posedge memRst) begin
    if (memRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= addr[AW-1:0];
        wdata_q <= wData;
        we_q    <= writeEnable;
        size_q  <= dsize;
      end
      if (do_access) begin
        mis_q <= op_mis;
        if (!op_we && !op_mis) begin
          rdata_q <= rdata_d;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reqReady  = (state_q == IDLE) || (state_q == RESP);
    respValid = (state_q == RESP);
    misalign  = (state_q == RESP) && mis_q;
    rData     = rdata_q;
  end

  // With single-cycle latency the access happens on the accept edge itself.
  generate
    if (LATENCY == 1) begin : g_direct
      assign op_addr   = addr[AW-1:0];
      assign op_wdata  = wData;
      assign op_we     = writeEnable;
      assign op_size   = dsize;
      assign do_access = accept;
    end else begin : g_latched
      assign op_addr   = addr_q;
      assign op_wdata  = wdata_q;
      assign op_we     = we_q;
      assign op_size   = size_q;
      assign do_access = (state_q == BUSY) && (cnt_q == '0);
    end
  endgenerate

  // Lane 0 holds the lowest address of a word, i.e. the most significant byte.
  always_comb begin
    op_mis   = 1'b0;
    op_bytes = 3'd4;
    rdata_d  = '0;
    unique case (op_size)
      2'b00: begin op_bytes = 3'd1; op_mis = 1'b0; end
      2'b01: begin op_bytes = 3'd2; op_mis = op_addr[0]; end
      default: begin op_bytes = 3'd4; op_mis = |op_addr[1:0]; end
    endcase
    op_off3  = {1'b0, op_addr[1:0]};
    op_shift = 3'd4 - op_bytes - op_off3;
    wr_word  = op_wdata << {op_shift, 3'b000};
    unique case (op_bytes)
      3'd1:    rdata_d = (rd_word >> {op_shift, 3'b000}) & 32'h0000_00FF;
      3'd2:    rdata_d = (rd_word >> {op_shift, 3'b000}) & 32'h0000_FFFF;
      default: rdata_d = rd_word;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_q [DEPTH];

      assign lane_we[gi] = do_access & op_we & ~op_mis
                         & (3'(gi) >= op_off3) & (3'(gi) < op_off3 + op_bytes);

      always_ff @(posedge clk) begin
        if (lane_we[gi]) begin
          mem_q[op_addr[AW-1:2]] <= wr_word[8*(3-gi) +: 8];
        end
      end

      assign rd_word[8*(3-gi) +: 8] = mem_q[op_addr[AW-1:2]];
    end
  endgenerate

endmodule
